key_expansion_stream: RTL and testbench

//   AES-128 key schedule generator; direct upstream stage of the round-key XOR stage.

---
 rtl/key_expansion_stream.sv | 137 +++++++++++++
 tb/tb_key_expansion_stream.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_expansion_stream.sv
// AES-128 iterative key schedule: pops a cipher key, streams round keys 0..NR one per cycle.
// Optional build macro KEY_EXP_REPLAY_EN replays each schedule BLOCKS_PER_KEY times per popped key.

module key_exp_sbox_lane (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign dout = SBOX[din];
endmodule

module key_expansion_stream #(
    parameter int NR             = 10,
    parameter int BLOCKS_PER_KEY = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [127:0] cipher_key,
    output logic         cipher_key_rd,
    input  logic         cipher_key_empty,
    output logic [127:0] round_key,
    output logic         round_key_wr,
    input  logic         round_key_full,
    output logic         busy
);
    localparam int NUM_LANES = 4;

    if (NR < 1 || NR > 10 || BLOCKS_PER_KEY < 1) begin : g_param_check
        $error("key_expansion_stream: NR must be 1..10 and BLOCKS_PER_KEY >= 1");
    end

    typedef enum logic {IDLE, EMIT} state_t;

    state_t       state, state_nxt;
    logic [127:0] cur_key;
    logic [3:0]   rnd;
    logic [7:0]   rcon;
    logic         pop, push, last_rnd, replay;

    logic [NUM_LANES-1:0][7:0] rot_word, sub_word;
    logic [31:0]  t, w0n, w1n, w2n, w3n;
    logic [127:0] next_key;
    logic [7:0]   rcon_nxt;

    // RotWord on w3: byte 0 of the result is byte 1 of w3.
    assign rot_word = {cur_key[103:96], cur_key[127:104]};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        key_exp_sbox_lane u_sbox (.din(rot_word[g]), .dout(sub_word[g]));
    end

    assign t        = sub_word ^ {24'h0, rcon};
    assign w0n      = cur_key[31:0]   ^ t;
    assign w1n      = cur_key[63:32]  ^ w0n;
    assign w2n      = cur_key[95:64]  ^ w1n;
    assign w3n      = cur_key[127:96] ^ w2n;
    assign next_key = {w3n, w2n, w1n, w0n};
    assign rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

    assign pop      = (state == IDLE) && !cipher_key_empty && !reset;
    assign push     = (state == EMIT) && !round_key_full && !reset;
    assign last_rnd = (rnd == 4'(NR));

    assign cipher_key_rd = pop;
    assign round_key_wr  = push;
    assign round_key     = cur_key;
    assign busy          = (state == EMIT);

`ifdef KEY_EXP_REPLAY_EN
    localparam int BW = $clog2(BLOCKS_PER_KEY + 1);
    logic [127:0] base_key;
    logic [BW-1:0] blk;

    assign replay = (blk < BW'(BLOCKS_PER_KEY - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            base_key <= '0;
            blk      <= '0;
        end else if (pop) begin
            base_key <= cipher_key;
            blk      <= '0;
        end else if (push && last_rnd) begin
            blk <= replay ? blk + 1'b1 : '0;
        end
    end
`else
    assign replay = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pop) state_nxt = EMIT;
            EMIT: if (push && last_rnd && !replay) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_key <= '0;
            rnd     <= '0;
            rcon    <= '0;
        end else if (pop) begin
            cur_key <= cipher_key;
            rnd     <= '0;
            rcon    <= 8'h01;
        end else if (push) begin
            if (!last_rnd) begin
                cur_key <= next_key;
                rnd     <= rnd + 4'd1;
                rcon    <= rcon_nxt;
            end else if (replay) begin
`ifdef KEY_EXP_REPLAY_EN
                cur_key <= base_key;
`endif
                rnd     <= '0;
                rcon    <= 8'h01;
            end
        end
    end
endmodule

// File: tb/tb_key_expansion_stream.sv
// Scoreboard bench for key_expansion_stream: GF(2^8)-derived S-box model, FIPS-197 A.1 goldens.
`timescale 1ns/1ps

module tb_key_expansion_stream;
    localparam int NR = 10;
`ifdef KEY_EXP_REPLAY_EN
    localparam int BPK = 3;
`else
    localparam int BPK = 1;
`endif
    localparam int PUSHES = BPK * (NR + 1);
    localparam logic [127:0] FIPS_KEY = 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b;
    localparam logic [127:0] FIPS_R1  = 128'h05766c2a_3939a323_b12c5488_17fefaa0;
    localparam logic [127:0] FIPS_R10 = 128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0;

    logic         clock = 1'b0;
    logic         reset;
    logic [127:0] cipher_key;
    logic         cipher_key_rd;
    logic         cipher_key_empty;
    logic [127:0] round_key;
    logic         round_key_wr;
    logic         round_key_full;
    logic         busy;

    key_expansion_stream #(.NR(NR), .BLOCKS_PER_KEY(BPK)) dut (
        .clock(clock), .reset(reset), .cipher_key(cipher_key), .cipher_key_rd(cipher_key_rd),
        .cipher_key_empty(cipher_key_empty), .round_key(round_key), .round_key_wr(round_key_wr),
        .round_key_full(round_key_full), .busy(busy)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0]   sb_tab [256];
    logic [127:0] kq[$];
    logic [127:0] sb[$];
    logic [127:0] hist[$];
    int           push_cyc[$];
    int           pop_cyc[$];
    logic [127:0] prev_rk;
    int  cyc = 0;
    int  full_left = 0;
    int  rst_cycles = 2;
    bit  stall_mode = 0;
    bit  rst_mode = 0;
    bit  rst_hit = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w [4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
        t = {sb_tab[w[3][7:0]], sb_tab[w[3][31:24]], sb_tab[w[3][23:16]], sb_tab[w[3][15:8]]};
        t[7:0] ^= rc;
        w[0] ^= t;
        w[1] ^= w[0];
        w[2] ^= w[1];
        w[3] ^= w[2];
        return {w[3], w[2], w[1], w[0]};
    endfunction

    task automatic model_push(input logic [127:0] key);
        for (int rep = 0; rep < BPK; rep++) begin
            logic [127:0] k = key;
            logic [7:0] rc = 8'h01;
            for (int r = 0; r <= NR; r++) begin
                sb.push_back(k);
                k  = next_rk(k, rc);
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
        end
    endtask

    task automatic drive_fifo();
        cipher_key       = (kq.size() != 0) ? kq[0] : '0;
        cipher_key_empty = (kq.size() == 0);
    endtask

    // Sample at the falling edge, drive 1 ns after the rising edge.
    task automatic tick();
        @(negedge clock);
        cyc++;
        if (reset) begin
            chk("rst_rd", cipher_key_rd, 0);
            chk("rst_wr", round_key_wr, 0);
            sb.delete();
        end else begin
            if (round_key_full && busy) begin
                chk("stall_wr", round_key_wr, 0);
                chk("stall_hold", round_key, prev_rk);
            end
            if (round_key_wr) begin
                if (sb.size() == 0) chk("extra_push", round_key_wr, 0);
                else                chk("push", round_key, sb.pop_front());
                hist.push_back(round_key);
                push_cyc.push_back(cyc);
                if (stall_mode && hist.size() == 5) full_left = 3;
                if (rst_mode && hist.size() == 6) begin
                    rst_cycles = 1;
                    rst_mode   = 0;
                    rst_hit    = 1;
                end
            end
            if (cipher_key_rd && kq.size() != 0) begin
                pop_cyc.push_back(cyc);
                model_push(kq.pop_front());
            end
        end
        @(posedge clock);
        #1;
        reset = (rst_cycles > 0);
        if (rst_cycles > 0) rst_cycles--;
        round_key_full = (full_left > 0);
        if (full_left > 0) full_left--;
        drive_fifo();
        prev_rk = round_key;
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (kq.size() == 0 && sb.size() == 0 && busy === 1'b0) done = 1;
        end
        chk(tag, done, 1);
    endtask

    task automatic clear_logs();
        hist.delete();
        push_cyc.delete();
        pop_cyc.delete();
    endtask

    initial begin
        reset = 1'b1;
        round_key_full = 1'b0;
        drive_fifo();
        build_sbox();
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_rk", round_key, '0);
        chk("rst_wr_idle", round_key_wr, 0);
        chk("rst_rd_empty", cipher_key_rd, 0);

        // FIPS-197 A.1, sink never full
        clear_logs();
        kq.push_back(FIPS_KEY);
        drive_fifo();
        run_until_idle("a1_done", 100);
        chk("a1_pushes", hist.size(), PUSHES);
        if (hist.size() == PUSHES && pop_cyc.size() == 1) begin
            chk("a1_r0", hist[0], FIPS_KEY);
            chk("a1_r1", hist[1], FIPS_R1);
            chk("a1_r10", hist[10], FIPS_R10);
            chk("a1_lat", push_cyc[0] - pop_cyc[0], 1);
            chk("a1_span", push_cyc[PUSHES-1] - push_cyc[0], PUSHES - 1);
`ifdef KEY_EXP_REPLAY_EN
            chk("rep_r11", hist[11], hist[0]);
            chk("rep_r32", hist[32], FIPS_R10);
`endif
        end

        // sink full for 3 cycles after push4
        clear_logs();
        stall_mode = 1;
        kq.push_back(FIPS_KEY);
        drive_fifo();
        run_until_idle("stall_done", 100);
        stall_mode = 0;
        chk("stall_pushes", hist.size(), PUSHES);
        if (hist.size() == PUSHES) begin
            chk("stall_r5_gap", push_cyc[5] - push_cyc[4], 4);
            chk("stall_r10", hist[10], FIPS_R10);
        end

        // two random keys back to back
        clear_logs();
        for (int i = 0; i < 2; i++) kq.push_back({$urandom, $urandom, $urandom, $urandom});
        drive_fifo();
        run_until_idle("b2b_done", 200);
        chk("b2b_pushes", hist.size(), 2 * PUSHES);
        chk("b2b_pops", pop_cyc.size(), 2);
        if (pop_cyc.size() == 2) chk("b2b_gap", pop_cyc[1] - pop_cyc[0], PUSHES + 1);

        // reset one cycle after push5; queued second key must start at round 0
        begin
            logic [127:0] key_c;
            int n_before;
            clear_logs();
            key_c = {$urandom, $urandom, $urandom, $urandom};
            kq.push_back({$urandom, $urandom, $urandom, $urandom});
            kq.push_back(key_c);
            drive_fifo();
            rst_mode = 1;
            for (int i = 0; i < 100 && !rst_hit; i++) tick();
            chk("mid_rst_hit", rst_hit, 1);
            tick();
            chk("mid_rst_busy", busy, 0);
            chk("mid_rst_rk", round_key, '0);
            chk("mid_rst_wr", round_key_wr, 0);
            n_before = hist.size();
            run_until_idle("mid_rst_done", 100);
            chk("mid_rst_pushes", hist.size() - n_before, PUSHES);
            if (hist.size() > n_before) chk("mid_rst_r0", hist[n_before], key_c);
        end

        // input FIFO empty for 20 cycles
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("empty_rd", cipher_key_rd, 0);
            chk("empty_wr", round_key_wr, 0);
            chk("empty_busy", busy, 0);
        end
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
